// File: rtl/label_bbox_tracker.sv
// Per-channel label bounding-box tracker.
// Each channel counts pixels matching its configured label and tracks their
// min/max box per frame. Frames with enough matches refresh a candidate box,
// and consecutive misses discard it. Candidates are published once per window.
module label_bbox_tracker #(
   parameter int unsigned NUM_CH        = 2,
   parameter int unsigned LABEL_W       = 3,
   parameter int unsigned COORD_W       = 10,
   parameter int unsigned THRESH        = 85,
   parameter int unsigned UPDATE_FRAMES = 90,
   parameter int unsigned MISS_FRAMES   = 4
) (
   input  logic                        pclk,
   input  logic                        reset,
   input  logic                        pix_valid,
   input  logic                        v_finish,
   input  logic [LABEL_W-1:0]          label_data,
   input  logic [COORD_W-1:0]          x_pixel,
   input  logic [COORD_W-1:0]          y_pixel,
   input  logic [NUM_CH*LABEL_W-1:0]   cfg_label,
   input  logic [NUM_CH-1:0]           freeze,
   output logic [NUM_CH*COORD_W-1:0]   x_min,
   output logic [NUM_CH*COORD_W-1:0]   x_max,
   output logic [NUM_CH*COORD_W-1:0]   y_min,
   output logic [NUM_CH*COORD_W-1:0]   y_max,
   output logic [NUM_CH-1:0]           box_present,
   output logic [NUM_CH-1:0]           box_valid
);

   localparam int unsigned CNT_W  = $clog2(THRESH + 1);
   localparam int unsigned MISS_W = $clog2(MISS_FRAMES + 1);
   localparam int unsigned FC_W   = (UPDATE_FRAMES > 1) ? $clog2(UPDATE_FRAMES) : 1;

   typedef struct packed {
      logic [COORD_W-1:0] x_min;
      logic [COORD_W-1:0] x_max;
      logic [COORD_W-1:0] y_min;
      logic [COORD_W-1:0] y_max;
   } box_t;

   localparam box_t BOX_SENTINEL = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0};

   box_t              acc_q      [NUM_CH];
   box_t              acc_d      [NUM_CH];
   box_t              close_box  [NUM_CH];
   logic [CNT_W-1:0]  cnt_q      [NUM_CH];
   logic [CNT_W-1:0]  cnt_d      [NUM_CH];
   logic [CNT_W-1:0]  close_cnt  [NUM_CH];
   logic              match      [NUM_CH];
   logic              hit        [NUM_CH];
   box_t              cand_box_q [NUM_CH];
   box_t              cand_box_d [NUM_CH];
   logic              cand_vld_q [NUM_CH];
   logic              cand_vld_d [NUM_CH];
   logic [MISS_W-1:0] miss_q     [NUM_CH];
   logic [MISS_W-1:0] miss_d     [NUM_CH];
   logic [FC_W-1:0]   frame_q;
   logic [FC_W-1:0]   frame_d;
   logic              publish;

   // Frame counter and publish strobe
   always_comb begin
      frame_d = frame_q;
      publish = v_finish && (frame_q == FC_W'(UPDATE_FRAMES - 1));
      if (v_finish) begin
         if (publish) frame_d = '0;
         else         frame_d = frame_q + FC_W'(1);
      end
   end

   // Per-channel accumulate, frame close and candidate update
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         match[c]      = pix_valid && (label_data == cfg_label[c*LABEL_W +: LABEL_W]);
         close_box[c]  = acc_q[c];
         close_cnt[c]  = cnt_q[c];
         cand_box_d[c] = cand_box_q[c];
         cand_vld_d[c] = cand_vld_q[c];
         miss_d[c]     = miss_q[c];
         if (match[c]) begin
            if (cnt_q[c] != CNT_W'(THRESH)) close_cnt[c] = cnt_q[c] + CNT_W'(1);
            if (x_pixel < acc_q[c].x_min) close_box[c].x_min = x_pixel;
            if (x_pixel > acc_q[c].x_max) close_box[c].x_max = x_pixel;
            if (y_pixel < acc_q[c].y_min) close_box[c].y_min = y_pixel;
            if (y_pixel > acc_q[c].y_max) close_box[c].y_max = y_pixel;
         end
         hit[c]   = (close_cnt[c] >= CNT_W'(THRESH));
         acc_d[c] = close_box[c];
         cnt_d[c] = close_cnt[c];
         if (v_finish) begin
            acc_d[c] = BOX_SENTINEL;
            cnt_d[c] = '0;
            if (hit[c]) begin
               cand_box_d[c] = close_box[c];
               cand_vld_d[c] = 1'b1;
               miss_d[c]     = '0;
            end else begin
               if (miss_q[c] != MISS_W'(MISS_FRAMES)) miss_d[c] = miss_q[c] + MISS_W'(1);
               if (miss_d[c] == MISS_W'(MISS_FRAMES)) cand_vld_d[c] = 1'b0;
            end
         end
      end
   end

   // Tracking state registers
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         frame_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c]      <= BOX_SENTINEL;
            cnt_q[c]      <= '0;
            cand_box_q[c] <= '0;
            cand_vld_q[c] <= 1'b0;
            miss_q[c]     <= '0;
         end
      end else begin
         frame_q <= frame_d;
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c]      <= acc_d[c];
            cnt_q[c]      <= cnt_d[c];
            cand_box_q[c] <= cand_box_d[c];
            cand_vld_q[c] <= cand_vld_d[c];
            miss_q[c]     <= miss_d[c];
         end
      end
   end

   // Published outputs, refreshed on the publish edge unless frozen
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         x_min       <= '0;
         x_max       <= '0;
         y_min       <= '0;
         y_max       <= '0;
         box_present <= '0;
         box_valid   <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            box_valid[c] <= 1'b0;
            if (publish && !freeze[c]) begin
               box_valid[c]                 <= 1'b1;
               box_present[c]               <= cand_vld_d[c];
               x_min[c*COORD_W +: COORD_W]  <= cand_vld_d[c] ? cand_box_d[c].x_min : '0;
               x_max[c*COORD_W +: COORD_W]  <= cand_vld_d[c] ? cand_box_d[c].x_max : '0;
               y_min[c*COORD_W +: COORD_W]  <= cand_vld_d[c] ? cand_box_d[c].y_min : '0;
               y_max[c*COORD_W +: COORD_W]  <= cand_vld_d[c] ? cand_box_d[c].y_max : '0;
            end
         end
      end
   end

endmodule
